countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 75 +++++++
 tb/tb_countdown_timer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, one-cycle terminal-count pulse and optional auto-reload.
// All outputs registered; load/decrement reach out one clock later; count is a plain enable.
module countdown_timer #(
    parameter int WIDTH       = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            out    <= '0;
            done   <= 1'b0;
            reload <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                out    <= load_val;
                reload <= load_val;
                if (load_val != '0) begin
                    state <= RUN;
                end else begin
                    // Zero-length countdown finishes immediately.
                    state <= DONE;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    RUN, PAUSE: begin
                        if (count) begin
                            if (out == ONE) begin
                                done <= 1'b1;
                                if (AUTO_RELOAD) begin
                                    out   <= reload;
                                    state <= RUN;
                                end else begin
                                    out   <= '0;
                                    state <= DONE;
                                end
                            end else if (out != '0) begin
                                out   <= out - ONE;
                                state <= RUN;
                            end
                        end else begin
                            state <= PAUSE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy = (state == RUN) || (state == PAUSE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed checks of countdown_timer in stop-at-zero and auto-reload builds.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       count;
    logic [3:0] out, out_ar;
    logic       done, done_ar;
    logic       busy, busy_ar;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .count(count),
        .out(out), .done(done), .busy(busy)
    );

    countdown_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .count(count),
        .out(out_ar), .done(done_ar), .busy(busy_ar)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic l, input logic [3:0] lv, input logic c);
        load     = l;
        load_val = lv;
        count    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect3(input string tag, input int o, input int d, input int b);
        check({tag, ".out"},  32'(out),  32'(o));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic expect3_ar(input string tag, input int o, input int d, input int b);
        check({tag, ".ar_out"},  32'(out_ar),  32'(o));
        check({tag, ".ar_done"}, 32'(done_ar), 32'(d));
        check({tag, ".ar_busy"}, 32'(busy_ar), 32'(b));
    endtask

    int seq_o[5]    = '{4, 3, 2, 1, 0};
    int seq_d[5]    = '{0, 0, 0, 0, 1};
    int seq_b[5]    = '{1, 1, 1, 1, 0};
    int pause_o[9]  = '{8, 7, 6, 6, 6, 6, 5, 4, 3};
    int pause_c[9]  = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
    int ar_o[9]     = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int ar_d[9]     = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

    initial begin
        reset    = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;
        count    = 1'b0;
        #12;
        expect3("reset", 0, 0, 0);
        expect3_ar("reset", 0, 0, 0);
        #8 reset = 1'b1;

        // Load 5 on the first edge after release, then count continuously.
        step(1'b1, 4'd5, 1'b1);
        expect3("ld5", 5, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd0, 1'b1);
            expect3($sformatf("cnt5_%0d", i), seq_o[i], seq_d[i], seq_b[i]);
        end
        step(1'b0, 4'd0, 1'b1);
        expect3("cnt5_hold", 0, 0, 0);

        // Pause in the middle of a countdown.
        step(1'b1, 4'd9, 1'b1);
        expect3("ld9", 9, 0, 1);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 4'd0, pause_c[i][0]);
            expect3($sformatf("pause_%0d", i), pause_o[i], 0, 1);
        end

        // Auto-reload sequence.
        step(1'b1, 4'd3, 1'b1);
        expect3_ar("ld3", 3, 0, 1);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 4'd0, 1'b1);
            expect3_ar($sformatf("ar_%0d", i), ar_o[i], ar_d[i], 1);
        end

        // Reload value of 1: done every enabled cycle in auto-reload mode.
        step(1'b1, 4'd1, 1'b1);
        expect3_ar("ld1", 1, 0, 1);
        expect3("ld1", 1, 0, 1);
        step(1'b0, 4'd0, 1'b1);
        expect3("ld1_term", 0, 1, 0);
        expect3_ar("ld1_r0", 1, 1, 1);
        for (int i = 1; i < 3; i++) begin
            step(1'b0, 4'd0, 1'b1);
            expect3_ar($sformatf("ld1_r%0d", i), 1, 1, 1);
        end

        // Load of zero goes straight to DONE with a pulse; no wrap afterwards.
        step(1'b1, 4'd0, 1'b1);
        expect3("ld0", 0, 1, 0);
        expect3_ar("ld0", 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'd0, 1'b1);
            expect3($sformatf("ld0_hold%0d", i), 0, 0, 0);
        end

        // Full range: 15 reaches zero exactly 15 edges after the load.
        step(1'b1, 4'd15, 1'b1);
        expect3("ld15", 15, 0, 1);
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 4'd0, 1'b1);
            expect3($sformatf("cnt15_%0d", i), 15 - i, (i == 15) ? 1 : 0, (i == 15) ? 0 : 1);
        end

        // Asynchronous reset mid-countdown.
        step(1'b1, 4'd6, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        step(1'b0, 4'd0, 1'b1);
        expect3("pre_rst", 4, 0, 1);
        #2 reset = 1'b0;
        #1;
        expect3("async_rst", 0, 0, 0);
        expect3_ar("async_rst", 0, 0, 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'd0, 1'b1);
            expect3($sformatf("post_rst%0d", i), 0, 0, 0);
        end

        // Load beats terminal count.
        step(1'b1, 4'd2, 1'b1);
        expect3("ld2", 2, 0, 1);
        step(1'b0, 4'd0, 1'b1);
        expect3("ld2_dec", 1, 0, 1);
        step(1'b1, 4'd7, 1'b1);
        expect3("ld_wins", 7, 0, 1);
        expect3_ar("ld_wins", 7, 0, 1);
        step(1'b0, 4'd0, 1'b1);
        expect3("ld_wins_dec", 6, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
